// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, constants and helpers for the data-memory arbiter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package dmem_pkg;

  // Access sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } dmem_state_e;

  // Requester index: 0 = core load/store unit, 1 = program-loader/DMA
  typedef logic dmem_port_t;

  localparam dmem_port_t PORT_CORE = 1'b0;
  localparam dmem_port_t PORT_DMA  = 1'b1;

  // Byte-offset field of a byte address into a 32-bit word
  localparam int unsigned BYTE_OFF_W     = 2;
  localparam int unsigned BYTES_PER_WORD = 4;

  function automatic logic word_aligned(input logic [BYTE_OFF_W-1:0] off);
    return (off == '0);
  endfunction

  function automatic logic [1:0] port_onehot(input dmem_port_t p);
    return (p == PORT_DMA) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// dmem_rr_pick: 2-way round-robin picker, one-hot grant from request vector and last winner.
// Latency: purely combinational.
// Backpressure: none; a lone requester always wins, on contention the port not granted last wins.
module dmem_rr_pick
  import dmem_pkg::*;
(
  input  logic [1:0] req_i,
  input  dmem_port_t last_i,
  output logic [1:0] gnt_o
);

  // Pass a single request straight through; break ties against the previous winner
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = (last_i == PORT_CORE) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and access sequencer for the shared word-addressed data memory.
// Latency: gnt in cycle T, rvalid in T+2 for a legal access, T+1 for a misaligned/out-of-range one.
// Backpressure: one access in flight, gnt only from IDLE; requesters hold fields until gnt.
// Build option DMEM_ARB_FIXED_PRIO_EN: port 0 always wins contention (no round-robin pointer).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1000,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // One past the last legal byte address, one bit wider so it never wraps
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(BYTES_PER_WORD * MEM_WORDS);

  dmem_state_e       state_q, state_d;
  dmem_port_t        owner_q;
  logic              we_q;
  logic              err_q;
  logic [1:0]        rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              mem_read_q, mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic [1:0]        req;
  logic [1:0]        pick;
  logic              gnt_vld;
  dmem_port_t        win;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              legal;

  assign req = {p1_req, p0_req};

`ifdef DMEM_ARB_FIXED_PRIO_EN
  // Port 0 has absolute priority whenever it requests
  always_comb begin
    pick = 2'b00;
    if (req[0]) begin
      pick = 2'b01;
    end else if (req[1]) begin
      pick = 2'b10;
    end
  end
`else
  dmem_port_t last_q;

  dmem_rr_pick u_pick (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (pick)
  );

  // Remember the last winner; reset as if port 1 won so port 0 is favoured first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= PORT_DMA;
    end else if (gnt_vld) begin
      last_q <= win;
    end
  end
`endif

  // Winner's request fields and the legality verdict, evaluated in the grant cycle
  assign gnt_vld   = (state_q == IDLE) && (pick != 2'b00);
  assign win       = pick[1];
  assign win_we    = win ? p1_we    : p0_we;
  assign win_addr  = win ? p1_addr  : p0_addr;
  assign win_wdata = win ? p1_wdata : p0_wdata;
  assign legal     = word_aligned(win_addr[BYTE_OFF_W-1:0]) && ({1'b0, win_addr} < ADDR_LIMIT);

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: illegal requests skip the memory cycle entirely
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gnt_vld) state_d = legal ? ACCESS : RESP;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the granted request, drive strobes for the ACCESS cycle only, build the response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q     <= PORT_CORE;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      rvalid_q    <= 2'b00;
      rdata_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      rvalid_q    <= 2'b00;
      if (gnt_vld) begin
        owner_q <= win;
        we_q    <= win_we;
        err_q   <= ~legal;
        if (legal) begin
          // Memory address/data only move for accesses that will really reach the array
          mem_read_q  <= ~win_we;
          mem_write_q <= win_we;
          mem_addr_q  <= win_addr;
          mem_wdata_q <= win_wdata;
        end else begin
          rvalid_q <= port_onehot(win);
          rdata_q  <= '0;
        end
      end
      if (state_q == ACCESS) begin
        rvalid_q <= port_onehot(owner_q);
        rdata_q  <= we_q ? '0 : mem_rdata;
      end
    end
  end

  assign p0_gnt    = gnt_vld & pick[0];
  assign p1_gnt    = gnt_vld & pick[1];
  assign p0_rvalid = rvalid_q[0];
  assign p1_rvalid = rvalid_q[1];
  assign p0_rdata  = rvalid_q[0] ? rdata_q : '0;
  assign p1_rdata  = rvalid_q[1] ? rdata_q : '0;
  assign p0_err    = rvalid_q[0] & err_q;
  assign p1_err    = rvalid_q[1] & err_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench with a response scoreboard for dmem_arbiter.
// Latency: expected responses carry the cycle they are due in.
// Backpressure: requests are held until gnt, then dropped.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_we, p0_gnt, p0_rvalid, p0_err;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic        p1_req, p1_we, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  dmem_arbiter #(.MEM_WORDS(1000), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write on the clock edge while mem_write is high
  logic [31:0] mem [0:999];
  logic [9:0]  widx;
  assign widx      = mem_addr[11:2];
  assign mem_rdata = (mem_addr < 32'd4000) ? mem[widx] : 32'hBAD0BAD0;
  always @(posedge clk) begin
    if (mem_write && mem_addr < 32'd4000) mem[widx] <= mem_wdata;
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic port, input logic [31:0] rdata, input logic err, input int lat);
    exp_t e;
    e.port  = port;
    e.rdata = rdata;
    e.err   = err;
    e.due   = cyc + lat;
    sb.push_back(e);
  endtask

  // Response monitor and strobe counters
  always @(negedge clk) begin
    if (p0_rvalid && p1_rvalid) begin
      chk("dual_rvalid", {p1_rvalid, p0_rvalid}, 32'h1);
    end else if (p0_rvalid || p1_rvalid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_rvalid: port %0d rvalid with nothing outstanding", p1_rvalid);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_port", {31'b0, p1_rvalid}, {31'b0, e.port});
        chk("rsp_rdata", p1_rvalid ? p1_rdata : p0_rdata, e.rdata);
        chk("rsp_err", {31'b0, p1_rvalid ? p1_err : p0_err}, {31'b0, e.err});
        chk("rsp_latency", cyc, e.due);
        chk("other_port_zero", p1_rvalid ? (p0_rdata | {31'b0, p0_err}) : (p1_rdata | {31'b0, p1_err}), 32'h0);
      end
    end
    if (mem_read && mem_write) chk("strobe_exclusive", 32'h1, 32'h0);
    if (mem_read)  rd_cnt++;
    if (mem_write) wr_cnt++;
  end

  task automatic set_req(input logic port, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end else begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end
  endtask

  task automatic wait_done();
    for (int n = 0; n < 10 && sb.size() != 0; n++) @(posedge clk);
    chk("drain", sb.size(), 32'h0);
    @(negedge clk);
  endtask

  // Single request on one port: wait for gnt, queue the expected response, release
  task automatic do_req(input logic port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input int lat);
    bit got;
    got = 1'b0;
    @(negedge clk);
    set_req(port, 1'b1, we, addr, wdata);
    for (int n = 0; n < 10 && !got; n++) begin
      #1;
      if ((port ? p1_gnt : p0_gnt) === 1'b1) begin
        got = 1'b1;
        push(port, exp_rdata, exp_err, lat);
      end else begin
        @(negedge clk);
      end
    end
    chk("gnt_seen", {31'b0, got}, 32'h1);
    @(negedge clk);
    set_req(port, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_done();
  endtask

  // Both ports hold read requests; grant k must go to port exp_order[k], 3 cycles apart
  task automatic contend(input int ngr, input logic [3:0] exp_order);
    int k;
    int lastc;
    k = 0;
    lastc = 0;
    @(negedge clk);
    set_req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    set_req(1'b1, 1'b1, 1'b0, 32'd3996, 32'h0);
    for (int n = 0; n < 40 && k < ngr; n++) begin
      #1;
      if (p0_gnt && p1_gnt) chk("gnt_onehot", 32'h3, 32'h1);
      if (p0_gnt || p1_gnt) begin
        chk("gnt_order", {31'b0, p1_gnt}, {31'b0, exp_order[k]});
        if (k > 0) chk("gnt_spacing", cyc - lastc, 32'd3);
        lastc = cyc;
        push(p1_gnt, p1_gnt ? 32'h12345678 : 32'hCAFEF00D, 1'b0, 2);
        k++;
      end
      @(negedge clk);
    end
    chk("contend_grants", k, ngr);
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_done();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0;
    int w0;
    for (int i = 0; i < 1000; i++) mem[i] = 32'h0;
    rst_n = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    #3 rst_n = 1'b0;
    #4;
    chk("rst_gnt", {30'b0, p1_gnt, p0_gnt}, 32'h0);
    chk("rst_rvalid", {30'b0, p1_rvalid, p0_rvalid}, 32'h0);
    chk("rst_err", {30'b0, p1_err, p0_err}, 32'h0);
    chk("rst_strobes", {30'b0, mem_write, mem_read}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_rdata", p0_rdata | p1_rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Write then read back on port 0: exactly one strobe cycle each
    w0 = wr_cnt;
    do_req(1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 32'h0, 1'b0, 2);
    chk("wr_pulse_cycles", wr_cnt - w0, 32'd1);
    chk("mem_word4", mem[4], 32'hCAFEF00D);
    r0 = rd_cnt;
    do_req(1'b0, 1'b0, 32'h10, 32'h0, 32'hCAFEF00D, 1'b0, 2);
    chk("rd_pulse_cycles", rd_cnt - r0, 32'd1);

    // Port 1 at the last legal word
    do_req(1'b1, 1'b1, 32'd3996, 32'h12345678, 32'h0, 1'b0, 2);
    chk("mem_word999", mem[999], 32'h12345678);
    do_req(1'b1, 1'b0, 32'd3996, 32'h0, 32'h12345678, 1'b0, 2);

    // Misaligned read on port 1: error one cycle after gnt, no read strobe
    r0 = rd_cnt;
    do_req(1'b1, 1'b0, 32'h6, 32'h0, 32'h0, 1'b1, 1);
    chk("misalign_no_read", rd_cnt - r0, 32'd0);

    // Out-of-range writes on port 0: no write strobe, last word untouched
    w0 = wr_cnt;
    do_req(1'b0, 1'b1, 32'd4000, 32'hBADBAD00, 32'h0, 1'b1, 1);
    do_req(1'b0, 1'b1, 32'hFFFFFFFC, 32'hBADBAD01, 32'h0, 1'b1, 1);
    chk("oor_no_write", wr_cnt - w0, 32'd0);
    chk("oor_word999", mem[999], 32'h12345678);

    // Withdrawal: port 1 requests only while port 0 owns the memory, then drops
    @(negedge clk);
    set_req(1'b0, 1'b1, 1'b1, 32'h30, 32'h55AA55AA);
    #1;
    chk("wd_p0_gnt", {31'b0, p0_gnt}, 32'h1);
    push(1'b0, 32'h0, 1'b0, 2);
    @(negedge clk);
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
    #1;
    chk("wd_p1_no_gnt_access", {31'b0, p1_gnt}, 32'h0);
    @(negedge clk);
    #1;
    chk("wd_p1_no_gnt_resp", {31'b0, p1_gnt}, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_done();
    repeat (3) @(negedge clk);
    chk("mem_word12", mem[12], 32'h55AA55AA);

    // Contention from reset with both ports held
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    contend(4, 4'b0000);
`else
    contend(4, 4'b1010);
`endif

    // Reset during ACCESS of a port 0 write: strobes drop at once, no response
    @(negedge clk);
    set_req(1'b0, 1'b1, 1'b1, 32'h20, 32'hDEADBEEF);
    #1;
    chk("abort_gnt", {31'b0, p0_gnt}, 32'h1);
    @(negedge clk);
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("abort_strobe_on", {31'b0, mem_write}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_wr_drop", {31'b0, mem_write}, 32'h0);
    chk("abort_rd_drop", {31'b0, mem_read}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
`ifdef DMEM_ARB_FIXED_PRIO_EN
    contend(2, 4'b0000);
`else
    contend(2, 4'b0010);
`endif

    chk("sb_empty_end", sb.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
